// File: rtl/bsg_nonsynth_cache_done_tracker.sv
// Multi-channel request/response completion tracker for cache benches: counts traffic,
// flags protocol errors and stalls, and pulses finish once all traces are done and drained.
`timescale 1ns/1ps
module bsg_nonsynth_cache_done_tracker #(
  parameter int channels_p        = 1,
  parameter int max_outstanding_p = 64,
  parameter int timeout_p         = 10000,
  parameter int drain_cycles_p    = 25,
  parameter int count_width_p     = 32,
  localparam int ow  = $clog2(max_outstanding_p + 1),
  localparam int chw = (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                en_i,
  input  logic [channels_p-1:0]               send_v_i,
  input  logic [channels_p-1:0]               send_ready_i,
  input  logic [channels_p-1:0]               recv_v_i,
  input  logic [channels_p-1:0]               recv_yumi_i,
  input  logic [channels_p-1:0]               trace_done_i,
  output logic [channels_p*ow-1:0]            outstanding_o,
  output logic [channels_p*count_width_p-1:0] sent_o,
  output logic [channels_p*count_width_p-1:0] recv_o,
  output logic                                all_done_o,
  output logic                                finish_o,
  output logic                                error_o,
  output logic [1:0]                          error_code_o,
  output logic [chw-1:0]                      error_chan_o
);

  localparam int tw = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam int dw = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_ERROR} state_e;

  state_e state_r, state_n;
  logic [dw-1:0] dcnt_r, dcnt_n;
  logic [tw-1:0] tcnt_r, tcnt_n;
  logic          finish_r, finish_n;
  logic [1:0]    code_r, code_n;
  logic [chw-1:0] chan_r, chan_n;

  logic [channels_p-1:0][ow-1:0]            outst_r;
  logic [channels_p-1:0][count_width_p-1:0] sent_r;
  logic [channels_p-1:0][count_width_p-1:0] recv_r;

  logic [channels_p-1:0] s, r, zero, under, over;
  logic all_zero, any_r, quiet, all_traces, t_clear, timeout_hit, drain_last;
  logic det_err;
  logic [1:0] det_code;
  logic [chw-1:0] det_chan, late_chan;

  assign s = send_v_i & send_ready_i;
  assign r = recv_v_i & recv_yumi_i;

  for (genvar i = 0; i < channels_p; i++) begin : g_chan
    assign zero[i]  = (outst_r[i] == '0);
    assign under[i] = r[i] & zero[i];
    assign over[i]  = s[i] & ~r[i] & (outst_r[i] == ow'(max_outstanding_p));
  end

  assign all_zero    = &zero;
  assign any_r       = |r;
  assign quiet       = ~|(s | r);
  assign all_traces  = &trace_done_i;
  assign t_clear     = any_r | all_zero;
  assign timeout_hit = (timeout_p != 0) && !t_clear && (tcnt_r == tw'(timeout_p - 1));
  assign drain_last  = (drain_cycles_p <= 1) || (dcnt_r == dw'(drain_cycles_p - 1));

  // Later loops override earlier ones, and each loop walks downward, so the
  // surviving cause is the highest-priority one on the lowest channel.
  always_comb begin
    det_err   = 1'b0;
    det_code  = 2'd0;
    det_chan  = '0;
    late_chan = '0;
    if (timeout_hit) begin
      det_err  = 1'b1;
      det_code = 2'd3;
      for (int i = channels_p - 1; i >= 0; i--)
        if (!zero[i]) det_chan = chw'(i);
    end
    for (int i = channels_p - 1; i >= 0; i--)
      if (over[i]) begin
        det_err  = 1'b1;
        det_code = 2'd2;
        det_chan = chw'(i);
      end
    for (int i = channels_p - 1; i >= 0; i--)
      if (under[i]) begin
        det_err  = 1'b1;
        det_code = 2'd1;
        det_chan = chw'(i);
      end
    for (int i = channels_p - 1; i >= 0; i--)
      if (s[i] | r[i]) late_chan = chw'(i);
  end

  always_comb begin
    state_n  = state_r;
    dcnt_n   = dcnt_r;
    tcnt_n   = tcnt_r;
    finish_n = 1'b0;
    code_n   = code_r;
    chan_n   = chan_r;
    if (en_i) begin
      if (t_clear || (timeout_p == 0)) tcnt_n = '0;
      else if (tcnt_r != tw'(timeout_p)) tcnt_n = tcnt_r + 1'b1;
      case (state_r)
        S_RUN, S_DRAIN: begin
          if (det_err) begin
            state_n = S_ERROR;
            code_n  = det_code;
            chan_n  = det_chan;
            dcnt_n  = '0;
          end else if (state_r == S_RUN) begin
            if (all_traces && all_zero && quiet) begin
              state_n = S_DRAIN;
              dcnt_n  = '0;
            end
          end else if (!quiet || !all_traces) begin
            state_n = S_RUN;
            dcnt_n  = '0;
          end else if (drain_last) begin
            state_n  = S_DONE;
            finish_n = 1'b1;
          end else begin
            dcnt_n = dcnt_r + 1'b1;
          end
        end
        S_DONE: begin
          if (!quiet) begin
            state_n = S_ERROR;
            code_n  = 2'd0;
            chan_n  = late_chan;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= S_RUN;
      dcnt_r   <= '0;
      tcnt_r   <= '0;
      finish_r <= 1'b0;
      code_r   <= 2'd0;
      chan_r   <= '0;
    end else begin
      state_r  <= state_n;
      dcnt_r   <= dcnt_n;
      tcnt_r   <= tcnt_n;
      finish_r <= finish_n;
      code_r   <= code_n;
      chan_r   <= chan_n;
    end
  end

  // A counter that would wrap past 0 or max_outstanding_p holds instead.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outst_r <= '0;
      sent_r  <= '0;
      recv_r  <= '0;
    end else if (en_i) begin
      for (int i = 0; i < channels_p; i++) begin
        if (s[i] && !r[i] && !over[i]) outst_r[i] <= outst_r[i] + 1'b1;
        else if (r[i] && !s[i] && !zero[i]) outst_r[i] <= outst_r[i] - 1'b1;
        if (s[i] && (sent_r[i] != '1)) sent_r[i] <= sent_r[i] + 1'b1;
        if (r[i] && (recv_r[i] != '1)) recv_r[i] <= recv_r[i] + 1'b1;
      end
    end
  end

  assign outstanding_o = outst_r;
  assign sent_o        = sent_r;
  assign recv_o        = recv_r;
  assign all_done_o    = (state_r == S_DONE);
  assign error_o       = (state_r == S_ERROR);
  assign finish_o      = finish_r;
  assign error_code_o  = code_r;
  assign error_chan_o  = chan_r;

endmodule
